counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_counter_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
//
// Purpose:
//   Walks a pair of externally driven counters toward a pair of requested
//   targets along the shortest modular path. Shadow copies of the driven
//   counter values are kept locally, so the controller always knows where the
//   counters sit without reading them back. A request can optionally clear
//   both counters before stepping begins.
//
// Configuration:
//   COUNTER_CTRL_ABORT_EN - when defined, adds an 'abort' input that returns
//   the controller to IDLE from CLEAR or STEP, keeping the shadows and
//   issuing no done pulse. Undefined by default.
//
// Ports:
//   clk                     single clock, rising edge
//   rst                     synchronous, active-high reset
//   req_valid / req_ready   request handshake (ready only in IDLE)
//   req_clear               with request: zero both counters before stepping
//   tgt1, tgt2              32-bit targets, latched on accept
//   abort                   (COUNTER_CTRL_ABORT_EN only) abandon request
//   start_over              clear command to the driven counter pair
//   en1, en2                step enables to the driven counters
//   direction1, direction2  1 = increment, 0 = decrement
//   s1, s2                  shadow copies of the driven counter values
//   busy                    request in progress (CLEAR or STEP)
//   done                    one-cycle pulse when both shadows hit targets
// -----------------------------------------------------------------------------
module counter_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_clear,
  input  logic [31:0] tgt1,
  input  logic [31:0] tgt2,
`ifdef COUNTER_CTRL_ABORT_EN
  input  logic        abort,
`endif
  output logic        start_over,
  output logic        en1,
  output logic        en2,
  output logic        direction1,
  output logic        direction2,
  output logic [31:0] s1,
  output logic [31:0] s2,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Half the modular range: a forward distance up to and including this
  // value is the short way round (the tie goes to incrementing).
  localparam logic [31:0] HALF_RANGE = 32'h8000_0000;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_tgt1;
  logic [31:0] r_tgt2;
  logic [31:0] r_s1;
  logic [31:0] r_s2;

  logic [31:0] w_diff1;
  logic [31:0] w_diff2;
  logic        w_at1;
  logic        w_at2;
  logic        w_up1;
  logic        w_up2;
  logic        w_accept;
  logic        w_abort;

  // Forward distance from shadow to target, modulo 2^32.
  assign w_diff1 = r_tgt1 - r_s1;
  assign w_diff2 = r_tgt2 - r_s2;
  assign w_at1   = (r_s1 == r_tgt1);
  assign w_at2   = (r_s2 == r_tgt2);
  assign w_up1   = (w_diff1 <= HALF_RANGE);
  assign w_up2   = (w_diff2 <= HALF_RANGE);

  assign w_accept = (r_state == IDLE) && req_valid;

`ifdef COUNTER_CTRL_ABORT_EN
  assign w_abort = abort && ((r_state == CLEAR) || (r_state == STEP));
`else
  assign w_abort = 1'b0;
`endif

  assign s1 = r_s1;
  assign s2 = r_s2;

  // Outputs depend only on registered state, targets and shadows; inputs
  // reach nothing here except the next-state choice.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves one unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    req_ready    = 1'b0;
    busy         = 1'b0;
    start_over   = 1'b0;
    en1          = 1'b0;
    en2          = 1'b0;
    direction1   = 1'b0;
    direction2   = 1'b0;
    done         = 1'b0;

    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next_state = req_clear ? CLEAR : STEP;
        end
      end
      CLEAR: begin
        busy         = 1'b1;
        start_over   = 1'b1;
        w_next_state = STEP;
      end
      STEP: begin
        busy       = 1'b1;
        en1        = !w_at1;
        en2        = !w_at2;
        direction1 = w_up1;
        direction2 = w_up2;
        if (w_at1 && w_at2) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase

    if (w_abort) begin
      w_next_state = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values of
    // the previous cycle, regardless of statement order.
    if (rst) begin
      r_state <= IDLE;
      r_tgt1  <= '0;
      r_tgt2  <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
    end else begin
      r_state <= w_next_state;

      if (w_accept) begin
        r_tgt1 <= tgt1;
        r_tgt2 <= tgt2;
      end

      // An abort freezes the shadows where they are.
      if (!w_abort) begin
        if (r_state == CLEAR) begin
          r_s1 <= '0;
          r_s2 <= '0;
        end
        if (en1) begin
          r_s1 <= direction1 ? r_s1 + 32'd1 : r_s1 - 32'd1;
        end
        if (en2) begin
          r_s2 <= direction2 ? r_s2 + 32'd1 : r_s2 - 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl
//
// Self-checking bench for counter_ctrl: a table of cycle-by-cycle vectors,
// hand-written multi-cycle sequences (wrap-around, reset mid-request,
// continuous request stream, shortest-path tie) and randomized requests
// checked against a distance-based reference model.
// -----------------------------------------------------------------------------
module tb_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_clear;
  logic [31:0] tgt1;
  logic [31:0] tgt2;
  logic        start_over;
  logic        en1;
  logic        en2;
  logic        direction1;
  logic        direction2;
  logic [31:0] s1;
  logic [31:0] s2;
  logic        busy;
  logic        done;
`ifdef COUNTER_CTRL_ABORT_EN
  logic        abort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model of the driven counters' positions.
  logic [31:0] m_s1;
  logic [31:0] m_s2;

  always #5 clk = ~clk;

  counter_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_clear  (req_clear),
    .tgt1       (tgt1),
    .tgt2       (tgt2),
`ifdef COUNTER_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .start_over (start_over),
    .en1        (en1),
    .en2        (en2),
    .direction1 (direction1),
    .direction2 (direction2),
    .s1         (s1),
    .s2         (s2),
    .busy       (busy),
    .done       (done)
  );

  // ctl = {rst, req_valid, req_clear}
  // flags = {req_ready, busy, start_over, en1, en2, direction1, direction2, done}
  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [7:0]  flags;
    logic [31:0] s1;
    logic [31:0] s2;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] flags_now();
    return {req_ready, busy, start_over, en1, en2, direction1, direction2, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic c,
                       input logic [31:0] a, input logic [31:0] b);
    rst       = r;
    req_valid = v;
    req_clear = c;
    tgt1      = a;
    tgt2      = b;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  // Runs one request from IDLE and checks every cycle up to the return to
  // IDLE. Expected values come from shortest modular distances: each counter
  // moves one step per cycle toward its target, the whole request takes
  // max(d1, d2) + 1 STEP cycles, then one DONE cycle.
  task automatic run_request(input int idx, input logic c,
                             input logic [31:0] t1, input logic [31:0] t2);
    logic [31:0] b1, b2, dd1, dd2, es1, es2;
    logic        up1, up2, e1, e2;
    logic [7:0]  ef;
    int          d1, d2, m, len, j, n1, n2;
    b1  = c ? 32'd0 : m_s1;
    b2  = c ? 32'd0 : m_s2;
    dd1 = t1 - b1;
    dd2 = t2 - b2;
    up1 = (dd1 <= 32'h8000_0000);
    up2 = (dd2 <= 32'h8000_0000);
    d1  = up1 ? int'(dd1) : int'(32'd0 - dd1);
    d2  = up2 ? int'(dd2) : int'(32'd0 - dd2);
    m   = (d1 > d2) ? d1 : d2;
    len = (c ? 1 : 0) + m + 2;

    drive(1'b0, 1'b1, c, t1, t2);
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= len; k++) begin
      j = k - (c ? 1 : 0);
      if (c && k == 1) begin
        ef  = 8'b0110_0000;
        es1 = m_s1;
        es2 = m_s2;
      end else if (j <= m + 1) begin
        e1  = (j - 1) < d1;
        e2  = (j - 1) < d2;
        n1  = e1 ? (j - 1) : d1;
        n2  = e2 ? (j - 1) : d2;
        es1 = up1 ? b1 + 32'(n1) : b1 - 32'(n1);
        es2 = up2 ? b2 + 32'(n2) : b2 - 32'(n2);
        ef  = {1'b0, 1'b1, 1'b0, e1, e2, (e1 ? up1 : 1'b1), (e2 ? up2 : 1'b1), 1'b0};
      end else begin
        ef  = 8'b0000_0001;
        es1 = t1;
        es2 = t2;
      end
      check($sformatf("rand%0d k%0d flags", idx, k), {24'd0, flags_now()}, {24'd0, ef});
      check($sformatf("rand%0d k%0d s1", idx, k), s1, es1);
      check($sformatf("rand%0d k%0d s2", idx, k), s2, es2);
      tick();
    end
    check($sformatf("rand%0d idle ready", idx), {31'd0, req_ready}, 32'd1);
    m_s1 = t1;
    m_s2 = t2;
  endtask

  initial begin
    logic [31:0] a, b, acc1, acc2, s1_at_done, t1r, t2r;
    logic        pre_ready, prev_done, cr;
    int          n_en1, n_en2, dir_bad, done_at, n_done;

`ifdef COUNTER_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

    // Cycle-by-cycle vectors: clear request (3,1), request (5,5) with an
    // ignored mid-request req_valid, zero-distance request, reset mid-CLEAR.
    vecs[0]  = '{3'b100, 32'd0,   32'd0,   8'b1000_0000, 32'd0, 32'd0};
    vecs[1]  = '{3'b011, 32'd3,   32'd1,   8'b0110_0000, 32'd0, 32'd0};
    vecs[2]  = '{3'b000, 32'd0,   32'd0,   8'b0101_1110, 32'd0, 32'd0};
    vecs[3]  = '{3'b000, 32'd0,   32'd0,   8'b0101_0110, 32'd1, 32'd1};
    vecs[4]  = '{3'b000, 32'd0,   32'd0,   8'b0101_0110, 32'd2, 32'd1};
    vecs[5]  = '{3'b000, 32'd0,   32'd0,   8'b0100_0110, 32'd3, 32'd1};
    vecs[6]  = '{3'b000, 32'd0,   32'd0,   8'b0000_0001, 32'd3, 32'd1};
    vecs[7]  = '{3'b000, 32'd0,   32'd0,   8'b1000_0000, 32'd3, 32'd1};
    vecs[8]  = '{3'b010, 32'd5,   32'd5,   8'b0101_1110, 32'd3, 32'd1};
    vecs[9]  = '{3'b010, 32'd100, 32'd100, 8'b0101_1110, 32'd4, 32'd2};
    vecs[10] = '{3'b000, 32'd0,   32'd0,   8'b0100_1110, 32'd5, 32'd3};
    vecs[11] = '{3'b000, 32'd0,   32'd0,   8'b0100_1110, 32'd5, 32'd4};
    vecs[12] = '{3'b000, 32'd0,   32'd0,   8'b0100_0110, 32'd5, 32'd5};
    vecs[13] = '{3'b000, 32'd0,   32'd0,   8'b0000_0001, 32'd5, 32'd5};
    vecs[14] = '{3'b000, 32'd0,   32'd0,   8'b1000_0000, 32'd5, 32'd5};
    vecs[15] = '{3'b010, 32'd5,   32'd5,   8'b0100_0110, 32'd5, 32'd5};
    vecs[16] = '{3'b000, 32'd0,   32'd0,   8'b0000_0001, 32'd5, 32'd5};
    vecs[17] = '{3'b000, 32'd0,   32'd0,   8'b1000_0000, 32'd5, 32'd5};
    vecs[18] = '{3'b011, 32'd9,   32'd9,   8'b0110_0000, 32'd5, 32'd5};
    vecs[19] = '{3'b100, 32'd0,   32'd0,   8'b1000_0000, 32'd0, 32'd0};

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].ctl[2], vecs[i].ctl[1], vecs[i].ctl[0], vecs[i].t1, vecs[i].t2);
      tick();
      check($sformatf("vec%0d flags", i), {24'd0, flags_now()}, {24'd0, vecs[i].flags});
      check($sformatf("vec%0d s1", i), s1, vecs[i].s1);
      check($sformatf("vec%0d s2", i), s2, vecs[i].s2);
    end

    // Wrap-around: from 0 down to FFFF_FFFE in two decrements.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd0);
    tick();
    req_valid  = 1'b0;
    n_en1      = 0;
    n_en2      = 0;
    dir_bad    = 0;
    done_at    = 0;
    s1_at_done = 32'd0;
    for (int k = 1; k <= 10; k++) begin
      if (en1) n_en1++;
      if (en2) n_en2++;
      if (en1 && direction1 !== 1'b0) dir_bad++;
      if (done && done_at == 0) begin
        done_at    = k;
        s1_at_done = s1;
      end
      tick();
    end
    check("wrap en1 cycles", 32'(n_en1), 32'd2);
    check("wrap en2 cycles", 32'(n_en2), 32'd0);
    check("wrap direction1", 32'(dir_bad), 32'd0);
    check("wrap done cycle", 32'(done_at), 32'd4);
    check("wrap s1", s1_at_done, 32'hFFFF_FFFE);

    // Shortest-path tie: distance 2^31 increments, 2^31+1 decrements.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0001);
    tick();
    req_valid = 1'b0;
    check("tie flags", {24'd0, flags_now()}, {24'd0, 8'b0101_1100});
    do_reset();
    check("tie reset flags", {24'd0, flags_now()}, {24'd0, 8'b1000_0000});
    check("tie reset s1", s1, 32'd0);

    // Reset mid-STEP at s1=2 heading to 10.
    drive(1'b0, 1'b1, 1'b0, 32'd10, 32'd0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("rst pre s1", s1, 32'd2);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    check("rst flags", {24'd0, flags_now()}, {24'd0, 8'b1000_0000});
    check("rst s1", s1, 32'd0);
    n_done = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) n_done++;
      tick();
    end
    check("rst no done", 32'(n_done), 32'd0);

    // Continuous req_valid with changing targets: only IDLE-cycle values are
    // taken, and IDLE (the next accept) follows each done by one cycle.
    do_reset();
    prev_done = 1'b0;
    acc1      = 32'd0;
    acc2      = 32'd0;
    n_done    = 0;
    for (int i = 0; i < 80; i++) begin
      a         = $urandom_range(0, 8);
      b         = $urandom_range(0, 8);
      cr        = 1'($urandom_range(0, 1));
      pre_ready = req_ready;
      drive(1'b0, 1'b1, cr, a, b);
      if (pre_ready) begin
        acc1 = a;
        acc2 = b;
      end
      tick();
      check($sformatf("hold%0d ready", i), {31'd0, req_ready}, {31'd0, prev_done});
      if (pre_ready) check($sformatf("hold%0d accept", i), {31'd0, busy}, 32'd1);
      if (done) begin
        check($sformatf("hold%0d s1", i), s1, acc1);
        check($sformatf("hold%0d s2", i), s2, acc2);
        n_done++;
      end
      prev_done = done;
    end
    req_valid = 1'b0;
    for (int k = 0; k < 30 && !req_ready; k++) tick();
    check("hold drain ready", {31'd0, req_ready}, 32'd1);
    check("hold done count", {31'd0, (n_done >= 3)}, 32'd1);

    // Randomized requests against the distance model.
    do_reset();
    m_s1 = 32'd0;
    m_s2 = 32'd0;
    for (int r = 0; r < 40; r++) begin
      cr  = ($urandom_range(0, 3) == 0);
      t1r = (cr ? 32'd0 : m_s1) + 32'($urandom_range(0, 48)) - 32'd24;
      t2r = (cr ? 32'd0 : m_s2) + 32'($urandom_range(0, 48)) - 32'd24;
      run_request(r, cr, t1r, t2r);
    end

`ifdef COUNTER_CTRL_ABORT_EN
    // Abort two steps into a five-step request.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort flags", {24'd0, flags_now()}, {24'd0, 8'b1000_0000});
    check("abort s1", s1, 32'd2);
    n_done = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) n_done++;
      tick();
    end
    check("abort no done", 32'(n_done), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
